// File: rtl/reg_file_32.sv
// 2^ADDR_WIDTH x DATA_WIDTH register file: two registered read ports, one write port, r0 reads zero.
// Define REGFILE_BYPASS_EN to make a read on the write edge return the incoming write data.
module reg_file_32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] ra_addr,
    input  logic [ADDR_WIDTH-1:0] rb_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic [DATA_WIDTH-1:0] b_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] a_next;
    logic [DATA_WIDTH-1:0] b_next;
    logic                  wr_hit;

    assign wr_hit = wr_en && (wr_addr != '0);

    always_comb begin
        a_next = (ra_addr == '0) ? '0 : mem[ra_addr];
        b_next = (rb_addr == '0) ? '0 : mem[rb_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (ra_addr == wr_addr)) begin
            a_next = wr_data;
        end
        if (wr_hit && (rb_addr == wr_addr)) begin
            b_next = wr_data;
        end
`endif
    end

    // An X enable resolves to the else path, so storage is left untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_hit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_data <= '0;
            b_data <= '0;
        end else if (rd_en) begin
            a_data <= a_next;
            b_data <= b_next;
        end
    end

endmodule

// File: tb/tb_reg_file_32.sv
// Directed and random checks of reg_file_32 against an array model of the register file.
// Model: without bypass reads see pre-edge contents, with REGFILE_BYPASS_EN post-edge contents.
module tb_reg_file_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] a_data;
    logic [31:0] b_data;

    logic [31:0] mdl [32];
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    reg_file_32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .ra_addr (ra_addr),
        .rb_addr (rb_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .a_data  (a_data),
        .b_data  (b_data)
    );

    task automatic cyc(input logic rst, input logic rd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
        logic do_wr;
        rst_n   = rst;
        rd_en   = rd;
        ra_addr = ra;
        rb_addr = rb;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        @(posedge clk);
        #1;
        do_wr = (we === 1'b1) && (wa != 5'd0);
        if (rst !== 1'b1) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            exp_a = 32'h0;
            exp_b = 32'h0;
        end else begin
`ifdef REGFILE_BYPASS_EN
            if (do_wr) mdl[wa] = wd;
            if (rd === 1'b1) begin
                exp_a = mdl[ra];
                exp_b = mdl[rb];
            end
`else
            if (rd === 1'b1) begin
                exp_a = mdl[ra];
                exp_b = mdl[rb];
            end
            if (do_wr) mdl[wa] = wd;
`endif
        end
    endtask

    task automatic chk(input string tag);
        n_cmp += 2;
        assert (a_data === exp_a) else begin
            n_bad++;
            $error("FAIL %s a_data got %h want %h", tag, a_data, exp_a);
        end
        assert (b_data === exp_b) else begin
            n_bad++;
            $error("FAIL %s b_data got %h want %h", tag, b_data, exp_b);
        end
    endtask

    initial begin
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  wa;
        logic [31:0] sum;

        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        exp_a = 32'h0;
        exp_b = 32'h0;

        cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("reset_state");

        // Test 1: reset clears a stored word
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        cyc(1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0);
        chk("pre_reset_r5");
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        cyc(1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0);
        chk("reset_r5");

        // Test 2: basic write/read
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h9);
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'h1);
        cyc(1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0);
        chk("basic_rw");
        sum = a_data + b_data;
        n_cmp++;
        assert (sum === 32'd10) else begin
            n_bad++;
            $error("FAIL alu_add got %h want %h", sum, 32'd10);
        end

        // Test 3: r0 is hardwired
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        cyc(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("r0_zero");
        cyc(1'b1, 1'b1, 5'd0, 5'd1, 1'b1, 5'd0, 32'hFFFFFFFF);
        chk("r0_no_bypass");

        // Test 4: same-edge hazard
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h11111111);
        cyc(1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h22222222);
        chk("hazard_edge");
        cyc(1'b1, 1'b1, 5'd7, 5'd1, 1'b0, 5'd0, 32'h0);
        chk("hazard_after");

        // Test 5: stall holds outputs
        cyc(1'b1, 1'b1, 5'd1, 5'd1, 1'b0, 5'd0, 32'h0);
        chk("stall_load");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 5'd2, 5'd2, 1'b0, 5'd0, 32'h0);
            chk("stall_hold");
        end
        cyc(1'b1, 1'b1, 5'd2, 5'd2, 1'b0, 5'd0, 32'h0);
        chk("stall_release");

        // Test 6: write lost under reset
        cyc(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'h0000FFFF);
        chk("reset_mid_write");
        cyc(1'b1, 1'b1, 5'd3, 5'd1, 1'b0, 5'd0, 32'h0);
        chk("reset_mid_write_r3");

        // X on wr_en must not write
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h44444444);
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'bx, 5'd4, 32'hBAD0BAD0);
        cyc(1'b1, 1'b1, 5'd4, 5'd4, 1'b0, 5'd0, 32'h0);
        chk("x_wr_en");

        // Random traffic, addresses biased toward collisions
        for (int n = 0; n < 400; n++) begin
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 59) != 0),
                ($urandom_range(0, 3) != 0),
                ra, rb,
                ($urandom_range(0, 2) != 0),
                wa, $urandom);
            chk("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_32.md
# reg_file_32

General-purpose register file for the MIPS datapath: 32 registers of 32 bits, two synchronous read ports and one synchronous write port. It sits directly upstream of `alu_32`; `a_data` and `b_data` drive the ALU `a` and `b` operands. Register 0 is hardwired to zero. A compile-time option adds same-cycle write-to-read bypass.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: register and port data width.
- `ADDR_WIDTH`, default 5: address width. Depth is 2^`ADDR_WIDTH`, so 32 registers by default.

Ports:
- `clk`  input  1  the single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `rd_en`  input  1  read enable; when high, both read ports capture on this edge.
- `ra_addr`  input  `ADDR_WIDTH`  port A read address.
- `rb_addr`  input  `ADDR_WIDTH`  port B read address.
- `wr_en`  input  1  write enable.
- `wr_addr`  input  `ADDR_WIDTH`  write address.
- `wr_data`  input  `DATA_WIDTH`  write data.
- `a_data`  output  `DATA_WIDTH`  registered port A read data; drives ALU `a`.
- `b_data`  output  `DATA_WIDTH`  registered port B read data; drives ALU `b`.

## Operation

- **Storage:** 2^`ADDR_WIDTH` words. Word 0 reads as 0 at all times.
- **Write:**
  - On a rising edge with `rst_n`=1, `wr_en`=1 and `wr_addr`≠0, `mem[wr_addr]` takes `wr_data`.
  - A write to address 0 is discarded silently.
- **Read:**
  - On a rising edge with `rst_n`=1 and `rd_en`=1, `a_data` takes the value at `ra_addr` and `b_data` takes the value at `rb_addr`.
  - With `rd_en`=0, both outputs hold their previous values. This is the stall behaviour.
- **Address 0:** a read of address 0 always returns 0, whatever the write activity.
- **Same address on both ports:** if `ra_addr`=`rb_addr`, both outputs return identical data.
- **Read of the address being written on the same edge:** the result depends on the `REGFILE_BYPASS_EN` macro (see Configuration).
- **Reset:**
  - On a rising edge with `rst_n`=0, every register, `a_data` and `b_data` become 0.
  - Any `wr_en` or `rd_en` asserted on that edge is ignored, so a write in flight when reset lands is lost.
  - Normal operation resumes on the first edge with `rst_n`=1.
- **Unknown inputs:** X or Z on the enables must not corrupt storage in simulation. An X on `wr_en` performs no write.

## Timing

- **Read latency:** 1 cycle. The address is presented before edge N; the data is valid on `a_data`/`b_data` after edge N.
- **Write latency:**
  - The write commits at edge N.
  - Without bypass, a read at edge N+1 or later returns the new value.
  - With bypass, a read at edge N itself already returns the new value.
- **Throughput:** one write and two reads per cycle, with no structural hazards.
- **Reset value:** `a_data`=0 and `b_data`=0 from the first reset edge. Outputs are undefined before the first edge; the bench must not check them there.
- **Combinational paths:** none from inputs to outputs. Both outputs come straight from flops.

## Configuration

- Macro: `REGFILE_BYPASS_EN`.
- **Defined (bypass on):**
  - If a read port's address equals `wr_addr`, `wr_en`=1 and the address is ≠0 on the same edge, that port captures `wr_data` instead of the stored word.
  - This gives write-before-read semantics, so the writeback-to-decode hazard needs no extra stall.
- **Undefined (bypass off):**
  - The read port captures the old stored value (read-before-write).
  - The pipeline must cover the hazard with a stall or forwarding.
- Address 0 is never bypassed in either mode.

## Test plan

1. **Reset.** Write 0xDEADBEEF to r5, then hold `rst_n`=0 for one edge, then read r5 on both ports -> `a_data`=`b_data`=0.
2. **Basic write/read.**
   - Write r1=0x00000009 and r2=0x00000001 on consecutive cycles.
   - Read ra=1, rb=2 -> `a_data`=9 and `b_data`=1 one cycle later.
   - Set ALU control=2 -> ALU result=10.
3. **Register 0.** Write 0xFFFFFFFF to r0, then read ra=0, rb=0 -> both 0.
4. **Same-edge hazard.** Preload r7=0x11111111. On one edge write r7=0x22222222 and read ra=7 -> `a_data`=0x22222222 with `REGFILE_BYPASS_EN` defined, or 0x11111111 without it. The next read returns 0x22222222 in both builds.
5. **Stall.** Read r1 into `a_data` (=9). Then drop `rd_en` and change `ra_addr` to 2 for three cycles -> `a_data` stays 9. Raise `rd_en` -> `a_data`=1 after the next edge.
6. **Reset mid-write.** Set `wr_en`=1, r3=0x0000FFFF in the same cycle as `rst_n`=0. Release reset and read r3 -> 0.
